// File: rtl/f_fetch_unit.sv
// Fetch stage: owns the PC, drives instruction memory and presents the
// fetched word, its PC, delay-slot flag and AdEL status to the D register.
module f_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        Req,
    input  logic        D_is_jump,
    input  logic        D_taken,
    input  logic [31:0] D_target,
    input  logic        D_eret,
    input  logic [31:0] EPC,
    output logic [31:0] i_inst_addr,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] F_instr,
    output logic [31:0] F_pc,
    output logic        F_BD,
    output logic [4:0]  F_ExcCode
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_r;
    logic [31:0] f_pc;
    logic [31:0] next_pc;
    logic        adel;

    // eret has no delay slot, so EPC is fetched in the same cycle
    assign f_pc = D_eret ? EPC : pc_r;

    assign adel = (f_pc[1:0] != 2'b00)
               || (f_pc < IM_LO)
               || (f_pc > IM_HI);

    assign i_inst_addr = f_pc;

    always_comb begin
        F_pc      = f_pc;
        F_instr   = adel ? 32'd0 : i_inst_rdata;
        F_BD      = D_is_jump & ~D_eret;
        F_ExcCode = adel ? EXC_ADEL : EXC_NONE;
        if (Req) begin
            F_pc      = HANDLER_PC;
            F_instr   = 32'd0;
            F_BD      = 1'b0;
            F_ExcCode = EXC_NONE;
        end
    end

    // Bad targets are loaded as-is; AdEL is flagged when presented
    always_comb begin
        next_pc = f_pc + 32'd4;
        if (Req) begin
            next_pc = HANDLER_PC;
        end else if (stall) begin
            next_pc = pc_r;
        end else if (D_taken) begin
            next_pc = D_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc;
        end
    end

endmodule
